up3_step_ctrl: RTL and testbench



---
 rtl/up3_step_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_up3_step_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/up3_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : up3_step_ctrl
// Description : Clock-enable generator for the up3 microprocessor. Turns the
//               bouncy active-low step button into a single-cycle step_en
//               pulse, or issues step_en at a fixed divided rate in free-run
//               mode.
// Ports       : clk        - board clock, all state on rising edge
//               reset      - asynchronous active-high reset
//               key_n      - raw step button, active-low, asynchronous
//               run_sw     - raw run/step slide switch, asynchronous
//               step_en    - one-clk-wide step pulse to the processor
//               run_led    - synchronized run_sw
//               step_count - steps issued since reset (optional counter)
// Options     : UP3_STEP_COUNT_EN - when defined, step_count is an 8-bit
//               wrapping count of step_en pulses; otherwise tied to 8'h00.
// Revision    : 1.0 - initial release
// ============================================================================
module up3_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic       run_sw,
    output logic       step_en,
    output logic       run_led,
    output logic [7:0] step_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic             r_key_s1, r_key_s2;
    logic             r_run_s1, r_run_s2;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_press_acc, r_press_acc;
    logic [DIV_W-1:0] r_div;
    logic             r_step_en;
    logic             w_pressed;
    logic             w_div_last;
    logic             w_step_src;

    // Two-FF synchronizers; the key chain resets to "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
            r_run_s1 <= 1'b0;
            r_run_s2 <= 1'b0;
        end else begin
            r_key_s1 <= key_n;
            r_key_s2 <= r_key_s1;
            r_run_s1 <= run_sw;
            r_run_s2 <= r_run_s1;
        end
    end

    assign w_pressed = ~r_key_s2;

    // Debounce FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_press_acc <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_press_acc <= w_press_acc;
        end
    end

    // The counter holds the number of consecutive samples seen at the new
    // level; a level change is accepted once it has been stable
    // DEBOUNCE_CYCLES samples. Only the press edge yields press_acc.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_acc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pressed) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            S_PRESS_WAIT: begin
                if (!w_pressed) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = '0;
                    w_press_acc = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_HELD: begin
                if (!w_pressed) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            S_RELEASE_WAIT: begin
                if (w_pressed) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Run-mode divider: parked at 0 whenever run mode is off, so the first
    // auto step always lands RUN_DIV cycles after run_led rises.
    assign w_div_last = (r_div == c_div_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (!r_run_s2 || w_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Exactly one source is selected by run_led; the self-mask guarantees
    // no back-to-back pulses across a mode change.
    assign w_step_src = (r_press_acc & ~r_run_s2) | (r_run_s2 & w_div_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step_en <= 1'b0;
        end else begin
            r_step_en <= w_step_src & ~r_step_en;
        end
    end

`ifdef UP3_STEP_COUNT_EN
    logic [7:0] r_step_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step_count <= 8'h00;
        end else if (r_step_en) begin
            r_step_count <= r_step_count + 8'd1;
        end
    end

    assign step_count = r_step_count;
`else
    assign step_count = 8'h00;
`endif

    assign step_en = r_step_en;
    assign run_led = r_run_s2;

endmodule
`default_nettype wire

// File: tb/tb_up3_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_up3_step_ctrl
// Description : Self-checking bench for up3_step_ctrl (DEBOUNCE_CYCLES=4,
//               RUN_DIV=8). A level/run-length reference model is compared
//               every cycle, plus directed timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up3_step_ctrl;

    localparam int D = 4;
    localparam int R = 8;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       key_n  = 1'b1;
    logic       run_sw = 1'b0;
    logic       step_en;
    logic       run_led;
    logic [7:0] step_count;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_pulse = 0;

    // Reference model state: sync stages, debounced level, run length of
    // samples disagreeing with that level, and plain-integer counters.
    bit m_k1, m_k2, m_r1, m_r2;
    bit m_lvl;
    bit m_acc;
    bit m_step;
    int m_run_len;
    int m_div;
    int m_cnt;

    up3_step_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .RUN_DIV        (R)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .run_sw    (run_sw),
        .step_en   (step_en),
        .run_led   (run_led),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_count();
`ifdef UP3_STEP_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_k1 = 1'b1; m_k2 = 1'b1; m_r1 = 1'b0; m_r2 = 1'b0;
        m_lvl = 1'b1; m_acc = 1'b0; m_step = 1'b0;
        m_run_len = 0; m_div = 0; m_cnt = 0;
    endtask

    // One rising edge: every next value is computed from pre-edge values.
    task automatic model_step();
        bit acc_now;
        bit step_nxt;
        acc_now = 1'b0;
        if (m_k2 != m_lvl) begin
            m_run_len++;
            if (m_run_len == D) begin
                m_lvl     = m_k2;
                m_run_len = 0;
                acc_now   = (m_k2 == 1'b0);
            end
        end else begin
            m_run_len = 0;
        end
        step_nxt = !m_step && ((m_acc && !m_r2) || (m_r2 && m_div == R - 1));
        m_cnt    = (m_cnt + (m_step ? 1 : 0)) % 256;
        m_div    = m_r2 ? (m_div + 1) % R : 0;
        m_k2 = m_k1; m_k1 = key_n;
        m_r2 = m_r1; m_r1 = run_sw;
        m_acc  = acc_now;
        m_step = step_nxt;
    endtask

    // Advance n cycles; compare against the model on each falling edge.
    task automatic tick(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            if (reset) model_reset();
            else       model_step();
            @(negedge clk);
            chk("step_en",    32'(step_en),    32'(m_step));
            chk("run_led",    32'(run_led),    32'(m_r2));
            chk("step_count", 32'(step_count), 32'(exp_count()));
            chk("divider",    32'(dut.r_div),  32'(m_div));
            if (step_en === 1'b1) n_pulse++;
        end
    endtask

    initial begin
        model_reset();
        tick(2);
        reset = 1'b0;
        chk("rst_step_en",    32'(step_en),     32'd0);
        chk("rst_run_led",    32'(run_led),     32'd0);
        chk("rst_step_count", 32'(step_count),  32'd0);
        chk("rst_deb_cnt",    32'(dut.r_cnt),   32'd0);
        tick(2);

        // Clean press: first low sample is loop step 1, pulse 6 edges later.
        key_n = 1'b0;
        n_pulse = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            chk("press_pulse", 32'(step_en), 32'(i == 7));
        end
        chk("press_once", 32'(n_pulse), 32'd1);
        key_n = 1'b1;
        n_pulse = 0;
        tick(12);
        chk("release_no_pulse", 32'(n_pulse), 32'd0);

        // Press bounce: 2 low, 1 high, then steady low.
        key_n = 1'b0; tick(2);
        key_n = 1'b1; tick(1);
        key_n = 1'b0;
        n_pulse = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk("bounce_pulse", 32'(step_en), 32'(i == 7));
        end
        chk("bounce_once", 32'(n_pulse), 32'd1);

        // Release chatter while held, then a genuine second press.
        n_pulse = 0;
        key_n = 1'b1; tick(1);
        key_n = 1'b0; tick(1);
        key_n = 1'b1; tick(10);
        chk("chatter_no_pulse", 32'(n_pulse), 32'd0);
        key_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk("second_press", 32'(step_en), 32'(i == 7));
        end
        key_n = 1'b1;
        tick(8);

        // Run mode: run_led rises one edge after the first sample, auto
        // steps follow every RUN_DIV edges; the button adds nothing.
        run_sw = 1'b1;
        n_pulse = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            chk("run_pulse", 32'(step_en), 32'(i == 10 || i == 18 || i == 26 || i == 34));
            if (i == 12) key_n = 1'b0;
            if (i == 24) key_n = 1'b1;
        end
        chk("run_pulse_cnt", 32'(n_pulse), 32'd4);
        run_sw = 1'b0;
        tick(3);
        n_pulse = 0;
        tick(10);
        chk("run_stop_pulses", 32'(n_pulse), 32'd0);
        chk("run_stop_div",    32'(dut.r_div), 32'd0);

        // Reset while the button is held.
        key_n = 1'b0;
        tick(10);
        reset = 1'b1;
        tick(3);
        chk("hold_rst_step_en", 32'(step_en),    32'd0);
        chk("hold_rst_count",   32'(step_count), 32'd0);
        chk("hold_rst_state",   32'(dut.r_state), 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk("post_rst_press", 32'(step_en), 32'(i == 7));
        end
        key_n = 1'b1;
        tick(8);

        // Counter wrap over 257 run-mode steps.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        run_sw = 1'b1;
        n_pulse = 0;
        for (int g = 0; g < 257 * R + 40 && n_pulse < 257; g++) tick(1);
        chk("wrap_reached", 32'(n_pulse), 32'd257);
        tick(1);
`ifdef UP3_STEP_COUNT_EN
        chk("wrap_count", 32'(step_count), 32'h01);
`else
        chk("wrap_count", 32'(step_count), 32'h00);
`endif
        run_sw = 1'b0;
        tick(12);

        // Randomized button/switch activity against the model.
        for (int b = 0; b < 250; b++) begin
            key_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) run_sw = ~run_sw;
            tick(int'($urandom_range(1, 10)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
